// File: rtl/latch_bank_loader.sv
// Serial-to-parallel write controller for a bank of D latches with async set/reset.
// Produces registered, glitch-free D/CE/SR/SRINIT with a setup and a hold cycle around each CE pulse.
module latch_bank_loader #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_bit,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              clr_req,
    input  logic [WIDTH-1:0]  init_val,
    output logic [WIDTH-1:0]  lat_d,
    output logic [DEPTH-1:0]  lat_ce,
    output logic              lat_sr,
    output logic [WIDTH-1:0]  lat_srinit,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SHIFT  = 3'd1;
    localparam logic [2:0] S_SETUP  = 3'd2;
    localparam logic [2:0] S_STROBE = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;
    localparam logic [2:0] S_CLEAR1 = 3'd5;
    localparam logic [2:0] S_CLEAR2 = 3'd6;

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WIDTH - 1);
    localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic [2:0]        state;
    logic [WIDTH-1:0]  shreg;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;

    logic [WIDTH-1:0]  shift_nxt;
    logic              addr_ok;
    logic [DEPTH-1:0]  ce_dec;

    // Only IDLE and SHIFT take bits; never depends on in_valid.
    assign in_ready = (state == S_IDLE) || (state == S_SHIFT);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        shift_nxt = (shreg << 1) | WIDTH'(in_bit);
        addr_ok   = ({1'b0, addr_q} < DEPTH_LIM);
        ce_dec    = '0;
        if (addr_ok) begin
            ce_dec = DEPTH'(1) << addr_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            shreg      <= '0;
            cnt        <= '0;
            addr_q     <= '0;
            lat_d      <= '0;
            lat_ce     <= '0;
            lat_sr     <= 1'b0;
            lat_srinit <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Clear wins over a bit offered in the same cycle; that bit is dropped.
                    if (clr_req) begin
                        lat_srinit <= init_val;
                        lat_sr     <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_CLEAR1;
                    end else if (in_valid) begin
                        addr_q <= in_addr;
                        shreg  <= WIDTH'(in_bit);
                        cnt    <= CNT_W'(1);
                        busy   <= 1'b1;
                        if (WIDTH == 1) begin
                            lat_d <= WIDTH'(in_bit);
                            state <= S_SETUP;
                        end else begin
                            state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    if (in_valid) begin
                        shreg <= shift_nxt;
                        cnt   <= cnt + 1'b1;
                        if (cnt == LAST_CNT) begin
                            lat_d <= shift_nxt;
                            state <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    lat_ce <= ce_dec;
                    err    <= !addr_ok;
                    state  <= S_STROBE;
                end
                S_STROBE: begin
                    lat_ce <= '0;
                    done   <= 1'b1;
                    state  <= S_HOLD;
                end
                S_HOLD: begin
                    shreg <= '0;
                    cnt   <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_CLEAR1: begin
                    done  <= 1'b1;
                    state <= S_CLEAR2;
                end
                S_CLEAR2: begin
                    lat_sr <= 1'b0;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    lat_ce <= '0;
                    lat_sr <= 1'b0;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch_bank_loader.sv
// Bench for latch_bank_loader: event-schedule reference model checked every cycle,
// a downstream latch-bank model, and literal expectations for each directed scenario.
module tb_latch_bank_loader;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              in_valid = 1'b0;
    logic              in_bit = 1'b0;
    logic [ADDR_W-1:0] in_addr = '0;
    logic              clr_req = 1'b0;
    logic [WIDTH-1:0]  init_val = '0;
    logic              in_ready;
    logic [WIDTH-1:0]  lat_d;
    logic [DEPTH-1:0]  lat_ce;
    logic              lat_sr;
    logic [WIDTH-1:0]  lat_srinit;
    logic              busy, done, err;

    latch_bank_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_bit(in_bit), .in_addr(in_addr), .clr_req(clr_req), .init_val(init_val),
        .lat_d(lat_d), .lat_ce(lat_ce), .lat_sr(lat_sr), .lat_srinit(lat_srinit),
        .busy(busy), .done(done), .err(err)
    );

    // Second instance with a non-power-of-two depth for the out-of-range case.
    logic        v3 = 1'b0;
    logic        b3 = 1'b0;
    logic [1:0]  a3 = 2'd0;
    logic        c3 = 1'b0;
    logic [7:0]  iv3 = 8'h00;
    logic        r3, sr3, busy3, done3, err3;
    logic [7:0]  d3, si3;
    logic [2:0]  ce3;

    latch_bank_loader #(.WIDTH(8), .DEPTH(3), .ADDR_W(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(r3),
        .in_bit(b3), .in_addr(a3), .clr_req(c3), .init_val(iv3),
        .lat_d(d3), .lat_ce(ce3), .lat_sr(sr3), .lat_srinit(si3),
        .busy(busy3), .done(done3), .err(err3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a completed transaction schedules its visible effects at absolute cycle numbers.
    int         cyc = 0;
    int         free_at = 0;
    int         m_cnt = 0;
    int         m_val = 0;
    int         m_addr = 0;
    logic [7:0] d_prev, d_new, si_prev, si_new, ce_mask;
    int         d_at, si_at, ce_at, done_at, err_at, sr_at;

    function automatic logic [7:0] exp_d(input int c);
        return (c >= d_at) ? d_new : d_prev;
    endfunction

    function automatic logic [7:0] exp_si(input int c);
        return (c >= si_at) ? si_new : si_prev;
    endfunction

    task automatic model_reset();
        free_at = 0;  m_cnt = 0;  m_val = 0;  m_addr = 0;
        d_prev = 8'h00;  d_new = 8'h00;  d_at = 0;
        si_prev = 8'h00; si_new = 8'h00; si_at = 0;
        ce_mask = 8'h00; ce_at = -10; done_at = -10; err_at = -10; sr_at = -10;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            if (cyc >= free_at) begin
                if (m_cnt == 0 && clr_req) begin
                    si_prev = exp_si(cyc);
                    si_new  = init_val;
                    si_at   = cyc + 1;
                    sr_at   = cyc + 1;
                    done_at = cyc + 2;
                    free_at = cyc + 3;
                end else if (in_valid) begin
                    if (m_cnt == 0) m_addr = int'(in_addr);
                    m_val = m_val * 2 + int'(in_bit);
                    m_cnt++;
                    if (m_cnt == WIDTH) begin
                        d_prev = exp_d(cyc);
                        d_new  = 8'(m_val);
                        d_at   = cyc + 1;
                        if (m_addr < DEPTH) begin
                            ce_mask = 8'(1 << m_addr);
                            ce_at   = cyc + 2;
                        end else begin
                            err_at = cyc + 2;
                        end
                        done_at = cyc + 3;
                        free_at = cyc + 4;
                        m_cnt = 0;
                        m_val = 0;
                    end
                end
            end
            cyc++;
        end
    end

    // Downstream latch bank and CE-pulse log, fed from the DUT pins.
    logic [7:0] latch [DEPTH];
    logic [3:0] ce_q[$];
    logic [7:0] dbef_q[$], dat_q[$], daft_q[$];
    logic [7:0] d_last = 8'h00;
    bit         aft_pend = 1'b0;
    int         sr_cnt = 0;
    int         done_cnt = 0;
    bit         chk_en = 1'b0;

    initial begin
        for (int i = 0; i < DEPTH; i++) latch[i] = 8'hxx;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready",   32'(in_ready),   32'(cyc >= free_at));
            check("busy",       32'(busy),       32'((cyc < free_at) || (m_cnt > 0)));
            check("lat_d",      32'(lat_d),      32'(exp_d(cyc)));
            check("lat_ce",     32'(lat_ce),     32'((cyc == ce_at) ? ce_mask : 8'h00));
            check("lat_sr",     32'(lat_sr),     32'((cyc == sr_at) || (cyc == sr_at + 1)));
            check("lat_srinit", 32'(lat_srinit), 32'(exp_si(cyc)));
            check("done",       32'(done),       32'(cyc == done_at));
            check("err",        32'(err),        32'(cyc == err_at));
            check("sr_ce_excl", 32'(lat_sr && (lat_ce != '0)), 32'(0));
            check("ce_onehot0", 32'($onehot0(lat_ce)), 32'(1));

            if (aft_pend) begin
                daft_q.push_back(lat_d);
                aft_pend = 1'b0;
            end
            if (lat_ce != '0) begin
                ce_q.push_back(lat_ce);
                dbef_q.push_back(d_last);
                dat_q.push_back(lat_d);
                aft_pend = 1'b1;
            end
            if (lat_sr) sr_cnt++;
            if (done) done_cnt++;
            d_last = lat_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (lat_sr) latch[i] = lat_srinit;
                else if (lat_ce[i]) latch[i] = lat_d;
            end
        end
    end

    bit ce3_seen = 1'b0;
    always @(negedge clk) if (ce3 != '0) ce3_seen = 1'b1;

    task automatic clear_log();
        ce_q.delete(); dbef_q.delete(); dat_q.delete(); daft_q.delete();
        sr_cnt = 0; done_cnt = 0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (cyc < free_at || m_cnt > 0) begin
            @(negedge clk);
            n++;
            if (n > 50) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wait_ready: loader not ready after %0d cycles", n);
                break;
            end
        end
    endtask

    // Stream one word MSB first; later bits carry a wrong address and optional clear noise.
    task automatic send_word(input logic [7:0] w, input logic [1:0] a, input int max_gap, input bit clr_noise);
        wait_ready();
        for (int i = 7; i >= 0; i--) begin
            int g;
            g = (max_gap > 0 && i < 7) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (g) begin
                in_valid = 1'b0;
                clr_req  = clr_noise;
                init_val = 8'h5A;
                @(negedge clk);
            end
            clr_req  = 1'b0;
            in_valid = 1'b1;
            in_bit   = w[i];
            in_addr  = (i == 7) ? a : ~a;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_addr  = '0;
    endtask

    initial begin
        logic [7:0] w3;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // Basic write.
        clear_log();
        send_word(8'hA5, 2'd2, 0, 1'b0);
        repeat (6) @(negedge clk);
        check("basic_ce_pulses", 32'(ce_q.size()), 32'd1);
        if (ce_q.size() == 1) begin
            check("basic_ce_mask",  32'(ce_q[0]),   32'h4);
            check("basic_d_before", 32'(dbef_q[0]), 32'hA5);
            check("basic_d_after",  32'(daft_q[0]), 32'hA5);
        end
        check("basic_latch2", 32'(latch[2]), 32'hA5);
        check("basic_done",   32'(done_cnt), 32'd1);

        // Stalled stream with clear requests during SHIFT.
        clear_log();
        send_word(8'h3C, 2'd0, 3, 1'b1);
        repeat (6) @(negedge clk);
        check("stall_ce_pulses", 32'(ce_q.size()), 32'd1);
        if (ce_q.size() == 1) check("stall_ce_mask", 32'(ce_q[0]), 32'h1);
        check("stall_latch0", 32'(latch[0]), 32'h3C);
        check("stall_no_sr",  32'(sr_cnt),   32'd0);
        check("stall_latch2", 32'(latch[2]), 32'hA5);

        // Clear with a competing bit.
        clear_log();
        wait_ready();
        clr_req = 1'b1; init_val = 8'hFF; in_valid = 1'b1; in_bit = 1'b1; in_addr = 2'd1;
        @(negedge clk);
        clr_req = 1'b0; in_valid = 1'b0; in_bit = 1'b0; init_val = 8'h00;
        repeat (5) @(negedge clk);
        check("clr_sr_cycles", 32'(sr_cnt),      32'd2);
        check("clr_no_ce",     32'(ce_q.size()), 32'd0);
        check("clr_done",      32'(done_cnt),    32'd1);
        check("clr_srinit",    32'(lat_srinit),  32'hFF);
        check("clr_busy_idle", 32'(busy),        32'd0);
        check("clr_d_kept",    32'(lat_d),       32'h3C);
        for (int i = 0; i < DEPTH; i++) check("clr_latch", 32'(latch[i]), 32'hFF);

        // Reset with three bits in the shifter.
        wait_ready();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_bit = 1'b1; in_addr = 2'd1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready),   32'd1);
        check("rst_lat_d",    32'(lat_d),      32'd0);
        check("rst_lat_ce",   32'(lat_ce),     32'd0);
        check("rst_lat_sr",   32'(lat_sr),     32'd0);
        check("rst_srinit",   32'(lat_srinit), 32'd0);
        check("rst_busy",     32'(busy),       32'd0);
        check("rst_done",     32'(done),       32'd0);
        check("rst_err",      32'(err),        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        send_word(8'hA5, 2'd2, 0, 1'b0);
        repeat (6) @(negedge clk);
        check("post_rst_lat_d",  32'(lat_d),       32'hA5);
        check("post_rst_latch2", 32'(latch[2]),    32'hA5);
        check("post_rst_pulses", 32'(ce_q.size()), 32'd1);

        // Back-to-back words.
        clear_log();
        send_word(8'h01, 2'd0, 0, 1'b0);
        send_word(8'h80, 2'd3, 0, 1'b0);
        repeat (6) @(negedge clk);
        check("b2b_pulses", 32'(ce_q.size()), 32'd2);
        if (ce_q.size() == 2 && daft_q.size() == 2) begin
            check("b2b_ce0",  32'(ce_q[0]),   32'h1);
            check("b2b_bef0", 32'(dbef_q[0]), 32'h01);
            check("b2b_aft0", 32'(daft_q[0]), 32'h01);
            check("b2b_ce1",  32'(ce_q[1]),   32'h8);
            check("b2b_bef1", 32'(dbef_q[1]), 32'h80);
            check("b2b_aft1", 32'(daft_q[1]), 32'h80);
        end
        check("b2b_latch0", 32'(latch[0]), 32'h01);
        check("b2b_latch3", 32'(latch[3]), 32'h80);

        // Out-of-range address on the three-word bank.
        w3 = 8'h11;
        check("oor_idle_ready", 32'(r3), 32'd1);
        for (int i = 7; i >= 0; i--) begin
            v3 = 1'b1; b3 = w3[i]; a3 = 2'd3;
            @(negedge clk);
        end
        v3 = 1'b0;
        check("oor_setup_d",     32'(d3),    32'h11);
        check("oor_setup_ready", 32'(r3),    32'd0);
        check("oor_setup_busy",  32'(busy3), 32'd1);
        @(negedge clk);
        check("oor_strobe_err",  32'(err3),  32'd1);
        check("oor_strobe_ce",   32'(ce3),   32'd0);
        @(negedge clk);
        check("oor_hold_done",   32'(done3), 32'd1);
        check("oor_hold_err",    32'(err3),  32'd0);
        @(negedge clk);
        check("oor_idle_ready2", 32'(r3),    32'd1);
        check("oor_idle_busy",   32'(busy3), 32'd0);
        check("oor_ce_never",    32'(ce3_seen), 32'd0);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
